// File: rtl/tdm_domain_arbiter.sv
// rtl/tdm_domain_arbiter.sv - time-division arbiter sharing one pipelined resource between Low and High domains
// The slot schedule is free-running so nothing Low-visible can depend on High activity.
module tdm_domain_arbiter #(
  parameter int DW          = 8,
  parameter int SLOT_CYCLES = 4,
  parameter int RES_LAT     = 1,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lo_req_valid,
  input  logic [DW-1:0] lo_req_data,
  output logic          lo_req_ready,
  input  logic          hi_req_valid,
  input  logic [DW-1:0] hi_req_data,
  output logic          hi_req_ready,
  output logic          cur_dom,
  output logic          res_valid,
  output logic          res_dom,
  output logic [DW-1:0] res_data,
  input  logic          res_rsp_valid,
  input  logic [DW-1:0] res_rsp_data,
  output logic          lo_rsp_valid,
  output logic [DW-1:0] lo_rsp_data,
  output logic          hi_rsp_valid,
  output logic [DW-1:0] hi_rsp_data
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] ISSUE_END = SW'(SLOT_CYCLES - RES_LAT);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);

  localparam logic [1:0] LO_ISSUE = 2'b00;
  localparam logic [1:0] LO_GUARD = 2'b01;
  localparam logic [1:0] HI_ISSUE = 2'b10;
  localparam logic [1:0] HI_GUARD = 2'b11;

  logic [SW-1:0] slot_cnt;
  logic [1:0]    state;
  logic          pop_lo;
  logic          pop_hi;

  logic [DW-1:0] lo_mem [FIFO_DEPTH];
  logic [PW-1:0] lo_wr_ptr;
  logic [PW-1:0] lo_rd_ptr;
  logic [CW-1:0] lo_cnt;
  logic          lo_push;

  logic [DW-1:0] hi_mem [FIFO_DEPTH];
  logic [PW-1:0] hi_wr_ptr;
  logic [PW-1:0] hi_rd_ptr;
  logic [CW-1:0] hi_cnt;
  logic          hi_push;

  logic [RES_LAT-1:0] tag_v;
  logic [RES_LAT-1:0] tag_d;
  logic               lo_hit;
  logic               hi_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      cur_dom  <= 1'b0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      cur_dom  <= ~cur_dom;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // The guard tail of each slot leaves room for the last response to drain.
  always_comb begin
    state  = {cur_dom, slot_cnt >= ISSUE_END};
    pop_lo = 1'b0;
    pop_hi = 1'b0;
    case (state)
      LO_ISSUE:           pop_lo = (lo_cnt != '0);
      HI_ISSUE:           pop_hi = (hi_cnt != '0);
      LO_GUARD, HI_GUARD: ;
      default:            ;
    endcase
  end

  assign lo_req_ready = rst_n && (lo_cnt != CNT_FULL);
  assign hi_req_ready = rst_n && (hi_cnt != CNT_FULL);
  assign lo_push      = lo_req_valid && lo_req_ready;
  assign hi_push      = hi_req_valid && hi_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_wr_ptr <= '0;
      lo_rd_ptr <= '0;
      lo_cnt    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) lo_mem[i] <= '0;
    end else begin
      if (lo_push) begin
        lo_mem[lo_wr_ptr] <= lo_req_data;
        lo_wr_ptr         <= (lo_wr_ptr == PTR_LAST) ? '0 : lo_wr_ptr + 1'b1;
      end
      if (pop_lo) lo_rd_ptr <= (lo_rd_ptr == PTR_LAST) ? '0 : lo_rd_ptr + 1'b1;
      case ({lo_push, pop_lo})
        2'b10:   lo_cnt <= lo_cnt + 1'b1;
        2'b01:   lo_cnt <= lo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_wr_ptr <= '0;
      hi_rd_ptr <= '0;
      hi_cnt    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) hi_mem[i] <= '0;
    end else begin
      if (hi_push) begin
        hi_mem[hi_wr_ptr] <= hi_req_data;
        hi_wr_ptr         <= (hi_wr_ptr == PTR_LAST) ? '0 : hi_wr_ptr + 1'b1;
      end
      if (pop_hi) hi_rd_ptr <= (hi_rd_ptr == PTR_LAST) ? '0 : hi_rd_ptr + 1'b1;
      case ({hi_push, pop_hi})
        2'b10:   hi_cnt <= hi_cnt + 1'b1;
        2'b01:   hi_cnt <= hi_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Idle cycles drive zero data so no High payload lingers on the shared bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      res_valid <= pop_lo || pop_hi;
      res_data  <= pop_lo ? lo_mem[lo_rd_ptr] : (pop_hi ? hi_mem[hi_rd_ptr] : '0);
    end
  end

  assign res_dom = cur_dom;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_d <= '0;
    end else begin
      tag_v <= RES_LAT'({tag_v, res_valid});
      tag_d <= RES_LAT'({tag_d, res_dom});
    end
  end

  // Routing follows the tag of the issue that produced the response, not the current slot.
  assign lo_hit = res_rsp_valid && tag_v[RES_LAT-1] && !tag_d[RES_LAT-1];
  assign hi_hit = res_rsp_valid && tag_v[RES_LAT-1] &&  tag_d[RES_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_rsp_valid <= 1'b0;
      lo_rsp_data  <= '0;
      hi_rsp_valid <= 1'b0;
      hi_rsp_data  <= '0;
    end else begin
      lo_rsp_valid <= lo_hit;
      lo_rsp_data  <= lo_hit ? res_rsp_data : '0;
      hi_rsp_valid <= hi_hit;
      hi_rsp_data  <= hi_hit ? res_rsp_data : '0;
    end
  end

endmodule

// File: tb/tb_tdm_domain_arbiter.sv
// tb/tb_tdm_domain_arbiter.sv - self-checking bench for tdm_domain_arbiter
module tb_tdm_domain_arbiter;

  localparam int SLOT  = 4;
  localparam int RL    = 1;
  localparam int DEPTH = 2;
  localparam int RING  = 16;
  localparam int TR    = 32;

  logic       clk;
  logic       rst_n;
  logic       lo_req_valid;
  logic [7:0] lo_req_data;
  logic       lo_req_ready;
  logic       hi_req_valid;
  logic [7:0] hi_req_data;
  logic       hi_req_ready;
  logic       cur_dom;
  logic       res_valid;
  logic       res_dom;
  logic [7:0] res_data;
  logic       res_rsp_valid;
  logic [7:0] res_rsp_data;
  logic       lo_rsp_valid;
  logic [7:0] lo_rsp_data;
  logic       hi_rsp_valid;
  logic [7:0] hi_rsp_data;

  int checks = 0;
  int errors = 0;

  tdm_domain_arbiter #(
    .DW(8), .SLOT_CYCLES(SLOT), .RES_LAT(RL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lo_req_valid(lo_req_valid), .lo_req_data(lo_req_data), .lo_req_ready(lo_req_ready),
    .hi_req_valid(hi_req_valid), .hi_req_data(hi_req_data), .hi_req_ready(hi_req_ready),
    .cur_dom(cur_dom), .res_valid(res_valid), .res_dom(res_dom), .res_data(res_data),
    .res_rsp_valid(res_rsp_valid), .res_rsp_data(res_rsp_data),
    .lo_rsp_valid(lo_rsp_valid), .lo_rsp_data(lo_rsp_data),
    .hi_rsp_valid(hi_rsp_valid), .hi_rsp_data(hi_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // Resource with a fixed one-cycle echo latency.
  logic       rsrc_v;
  logic [7:0] rsrc_d;
  always @(negedge clk) begin
    rsrc_v = res_valid;
    rsrc_d = res_data;
  end

  // Model: cycle index gives slot/owner; queues hold FIFO contents; ring holds scheduled outputs.
  int         mcyc;
  int         m_slot;
  int         m_dom;
  int         k;
  int         k1;
  int         k3;
  logic       m_lo_rdy;
  logic       m_hi_rdy;
  logic [7:0] m_d;
  logic [7:0] lo_q[$];
  logic [7:0] hi_q[$];
  logic       e_iss_v [RING];
  logic [7:0] e_iss_d [RING];
  logic       e_lo_v  [RING];
  logic [7:0] e_lo_d  [RING];
  logic       e_hi_v  [RING];
  logic [7:0] e_hi_d  [RING];
  logic [2:0] trace [2][TR];
  int         rec_run = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      mcyc = 0;
      lo_q.delete();
      hi_q.delete();
      for (int i = 0; i < RING; i++) begin
        e_iss_v[i] = 0; e_iss_d[i] = 0; e_lo_v[i] = 0; e_lo_d[i] = 0; e_hi_v[i] = 0; e_hi_d[i] = 0;
      end
      chk("rst_cur_dom", cur_dom, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_lo_rsp", {lo_rsp_valid, lo_rsp_data}, 0);
      chk("rst_hi_rsp", {hi_rsp_valid, hi_rsp_data}, 0);
    end else begin
      m_slot   = mcyc % SLOT;
      m_dom    = (mcyc / SLOT) % 2;
      k        = mcyc % RING;
      m_lo_rdy = lo_q.size() < DEPTH;
      m_hi_rdy = hi_q.size() < DEPTH;
      chk("cur_dom", cur_dom, 32'(m_dom));
      chk("res_dom", res_dom, 32'(m_dom));
      chk("lo_req_ready", lo_req_ready, m_lo_rdy);
      chk("hi_req_ready", hi_req_ready, m_hi_rdy);
      chk("res_valid", res_valid, e_iss_v[k]);
      chk("res_data", res_data, e_iss_d[k]);
      chk("lo_rsp_valid", lo_rsp_valid, e_lo_v[k]);
      chk("lo_rsp_data", lo_rsp_data, e_lo_d[k]);
      chk("hi_rsp_valid", hi_rsp_valid, e_hi_v[k]);
      chk("hi_rsp_data", hi_rsp_data, e_hi_d[k]);
      if (rec_run >= 0 && mcyc < TR)
        trace[rec_run][mcyc] = {lo_req_ready, res_valid && !res_dom, lo_rsp_valid};
      e_iss_v[k] = 0; e_iss_d[k] = 0; e_lo_v[k] = 0; e_lo_d[k] = 0; e_hi_v[k] = 0; e_hi_d[k] = 0;
      if (m_slot < SLOT - RL) begin
        k1 = (mcyc + 1) % RING;
        k3 = (mcyc + 2 + RL) % RING;
        if (m_dom == 0 && lo_q.size() > 0) begin
          m_d = lo_q.pop_front();
          e_iss_v[k1] = 1; e_iss_d[k1] = m_d;
          e_lo_v[k3]  = 1; e_lo_d[k3]  = m_d;
        end else if (m_dom == 1 && hi_q.size() > 0) begin
          m_d = hi_q.pop_front();
          e_iss_v[k1] = 1; e_iss_d[k1] = m_d;
          e_hi_v[k3]  = 1; e_hi_d[k3]  = m_d;
        end
      end
      if (lo_req_valid && m_lo_rdy) lo_q.push_back(lo_req_data);
      if (hi_req_valid && m_hi_rdy) hi_q.push_back(hi_req_data);
      mcyc++;
    end
  end

  task automatic drive(input logic lv, input logic [7:0] ld, input logic hv, input logic [7:0] hd);
    lo_req_valid = lv;
    lo_req_data  = ld;
    hi_req_valid = hv;
    hi_req_data  = hd;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    res_rsp_valid = rsrc_v;
    res_rsp_data  = rsrc_d;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    res_rsp_valid = 1'b0;
    res_rsp_data  = 8'h00;
    repeat (2) @(negedge clk);
    adv();
    rst_n = 1'b1;
  endtask

  task automatic low_stream(input int run, input logic flood);
    int   idx;
    logic acc;
    do_reset();
    rec_run = run;
    idx     = 0;
    for (int c = 0; c < TR; c++) begin
      drive(idx < 6, 8'(idx + 1), flood, 8'(8'h80 + c));
      @(negedge clk);
      acc = lo_req_valid && lo_req_ready;
      adv();
      if (acc) idx++;
    end
    rec_run = -1;
    chk("stream_all_pushed", idx, 6);
  endtask

  initial begin
    int   idx;
    logic acc;
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    res_rsp_valid = 1'b0;
    res_rsp_data  = 8'h00;

    // Single Low and High transactions with hand-computed timing.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive(c == 0, 8'h11, c == 0, 8'hA5);
      @(negedge clk);
      case (c)
        0: begin
          chk("c0_cur_dom", cur_dom, 0);
          chk("c0_lo_ready", lo_req_ready, 1);
          chk("c0_hi_ready", hi_req_ready, 1);
          chk("c0_res_valid", res_valid, 0);
        end
        2: chk("c2_issue_lo", {res_valid, res_dom, res_data}, {1'b1, 1'b0, 8'h11});
        3: chk("c3_cur_dom", cur_dom, 0);
        4: begin
          chk("c4_cur_dom", cur_dom, 1);
          chk("c4_lo_rsp", {lo_rsp_valid, lo_rsp_data}, {1'b1, 8'h11});
          chk("c4_hi_rsp_valid", hi_rsp_valid, 0);
          chk("c4_res_valid", res_valid, 0);
        end
        5: chk("c5_issue_hi", {res_valid, res_dom, res_data}, {1'b1, 1'b1, 8'hA5});
        7: begin
          chk("c7_hi_rsp", {hi_rsp_valid, hi_rsp_data}, {1'b1, 8'hA5});
          chk("c7_lo_rsp_valid", lo_rsp_valid, 0);
        end
        8:  chk("c8_cur_dom", cur_dom, 0);
        12: chk("c12_cur_dom", cur_dom, 1);
        default: ;
      endcase
      adv();
    end

    // Low FIFO fills during the High slot; guard and High slot suppress Low issue.
    do_reset();
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      drive((c >= 4) && (idx < 5), 8'(8'h21 + idx), 0, 0);
      @(negedge clk);
      case (c)
        5:  chk("full_c5_ready", lo_req_ready, 1);
        6:  chk("full_c6_ready", lo_req_ready, 0);
        7:  chk("full_c7_ready", lo_req_ready, 0);
        8:  chk("full_c8_ready", lo_req_ready, 0);
        9:  chk("full_c9_ready", lo_req_ready, 1);
        11: chk("full_c11_issue", {res_valid, res_data}, {1'b1, 8'h23});
        12: chk("full_c12_guard", res_valid, 0);
        16: chk("full_c16_hislot", res_valid, 0);
        17: chk("full_c17_issue", {res_valid, res_dom, res_data}, {1'b1, 1'b0, 8'h24});
        default: ;
      endcase
      acc = lo_req_valid && lo_req_ready;
      adv();
      if (acc) idx++;
    end

    // Low-visible timing must not change when High floods.
    low_stream(0, 1'b0);
    low_stream(1, 1'b1);
    for (int c = 0; c < TR; c++)
      chk($sformatf("lo_trace_c%0d", c), trace[1][c], trace[0][c]);

    // Reset with both FIFOs full and a Low response on the output.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(c == 3 || c == 4 || c == 10 || c == 11,
            (c == 3) ? 8'h31 : (c == 4) ? 8'h32 : (c == 10) ? 8'h33 : 8'h34,
            c == 8 || c == 9, (c == 8) ? 8'hB1 : 8'hB2);
      @(negedge clk);
      if (c == 9)  chk("mr_c9_issue", {res_valid, res_data}, {1'b1, 8'h31});
      if (c == 10) chk("mr_c10_issue", {res_valid, res_data}, {1'b1, 8'h32});
      adv();
    end
    drive(0, 0, 0, 0);
    chk("mr_pre_lo_rsp", {lo_rsp_valid, lo_rsp_data}, {1'b1, 8'h32});
    chk("mr_pre_full", {lo_req_ready, hi_req_ready, cur_dom}, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("mr_now_res", {res_valid, res_data}, 0);
    chk("mr_now_lo_rsp", {lo_rsp_valid, lo_rsp_data}, 0);
    chk("mr_now_hi_rsp", {hi_rsp_valid, hi_rsp_data}, 0);
    chk("mr_now_dom", {cur_dom, res_dom}, 0);
    repeat (2) @(negedge clk);
    adv();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 2) begin
        res_rsp_valid = 1'b1;
        res_rsp_data  = 8'h77;
      end
      @(negedge clk);
      if (c == 0) chk("mr_post_ready", {lo_req_ready, hi_req_ready}, 2'b11);
      if (c == 1 || c == 2) chk("mr_post_no_stale", {lo_rsp_valid, hi_rsp_valid}, 0);
      if (c >= 1 && c <= 3) chk("mr_post_no_issue", res_valid, 0);
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
